// File: rtl/stack_pkg.sv
// Types and defaults shared by the bit stack and its command front end.
`timescale 1ns/1ps
package stack_pkg;
  localparam int DEFAULT_DATA_W = 1;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_PUSH,
    CMD_POP
  } stack_cmd_t;
endpackage

// File: rtl/btn_debounce.sv
// One raw button -> 2-flop synchroniser, stable-count debounce, single-cycle rise pulse.
// The rise pulse is combinational from the debounced state and its one-cycle delay.
`timescale 1ns/1ps
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic          deb, deb_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_d <= deb;
      // Any agreeing sample restarts the stability run.
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        deb <= ~deb;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = deb & ~deb_d;
endmodule

// File: rtl/stack_cmd_frontend.sv
// Conditions raw push/pop buttons and data pins into clean, FULL/EMPTY-gated stack commands.
// Simultaneous requests: push goes first, pop is held one cycle in a pending flag.
`timescale 1ns/1ps
module stack_cmd_frontend
  import stack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DATA_W          = DEFAULT_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BTN_PUSH,
  input  logic              BTN_POP,
  input  logic [DATA_W-1:0] DATA_RAW,
  input  logic              FULL,
  input  logic              EMPTY,
  output logic              PUSH,
  output logic              POP,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              REJECT
);
  logic              push_req, pop_req;
  logic              pop_pend, pend_next;
  logic              rej;
  logic [DATA_W-1:0] data_s1, data_s2;
  stack_cmd_t        cmd;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_push (
    .clk  (CLK),
    .rst  (RST),
    .btn  (BTN_PUSH),
    .rise (push_req)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pop (
    .clk  (CLK),
    .rst  (RST),
    .btn  (BTN_POP),
    .rise (pop_req)
  );

  // A push always wins the cycle; any outstanding pop folds into one pending pop.
  always_comb begin
    cmd       = CMD_NONE;
    rej       = 1'b0;
    pend_next = 1'b0;
    if (push_req) begin
      pend_next = pop_req | pop_pend;
      if (FULL) rej = 1'b1;
      else      cmd = CMD_PUSH;
    end else if (pop_req | pop_pend) begin
      if (EMPTY) rej = 1'b1;
      else       cmd = CMD_POP;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_s1  <= '0;
      data_s2  <= '0;
      pop_pend <= 1'b0;
      PUSH     <= 1'b0;
      POP      <= 1'b0;
      REJECT   <= 1'b0;
      DATA_OUT <= '0;
    end else begin
      data_s1  <= DATA_RAW;
      data_s2  <= data_s1;
      pop_pend <= pend_next;
      PUSH     <= (cmd == CMD_PUSH);
      POP      <= (cmd == CMD_POP);
      REJECT   <= rej;
      if (cmd == CMD_PUSH) DATA_OUT <= data_s2;
    end
  end
endmodule

// File: tb/tb_stack_cmd_frontend.sv
// Directed scenarios plus random button/flag traffic checked against a sample-window reference model.
`timescale 1ns/1ps
module tb_stack_cmd_frontend;
  localparam int D = 4;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         BTN_PUSH = 1'b0, BTN_POP = 1'b0, FULL = 1'b0, EMPTY = 1'b0;
  logic [W-1:0] DATA_RAW = '0;
  logic         PUSH, POP, REJECT;
  logic [W-1:0] DATA_OUT;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  stack_cmd_frontend #(.DEBOUNCE_CYCLES(D), .DATA_W(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BTN_PUSH (BTN_PUSH),
    .BTN_POP  (BTN_POP),
    .DATA_RAW (DATA_RAW),
    .FULL     (FULL),
    .EMPTY    (EMPTY),
    .PUSH     (PUSH),
    .POP      (POP),
    .DATA_OUT (DATA_OUT),
    .REJECT   (REJECT)
  );

  // Reference model: raw samples per edge; a button's clean state flips once the
  // last D samples the debouncer could have seen (raw two edges old) all disagree with it.
  logic [D+1:0] hp = '0, hq = '0;
  logic [W-1:0] hd0 = '0, hd1 = '0, hd2 = '0;
  logic         m_deb_p = 0, m_deb_q = 0, m_rise_p = 0, m_rise_q = 0, m_pend = 0;
  logic         m_push = 0, m_pop = 0, m_rej = 0;
  logic [W-1:0] m_data = '0;
  logic         rp, rq;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      hp = '0; hq = '0; hd0 = '0; hd1 = '0; hd2 = '0;
      m_deb_p = 0; m_deb_q = 0; m_rise_p = 0; m_rise_q = 0; m_pend = 0;
      m_push = 0; m_pop = 0; m_rej = 0; m_data = '0;
    end else begin
      rp = m_rise_p;
      rq = m_rise_q | m_pend;
      hp = {hp[D:0], BTN_PUSH};
      hq = {hq[D:0], BTN_POP};
      hd2 = hd1; hd1 = hd0; hd0 = DATA_RAW;
      m_push = rp && !FULL;
      m_pop  = !rp && rq && !EMPTY;
      m_rej  = rp ? FULL : (rq && EMPTY);
      m_pend = rp && rq;
      if (m_push) m_data = hd2;
      m_rise_p = 0;
      if (hp[D+1:2] == {D{~m_deb_p}}) begin m_deb_p = ~m_deb_p; m_rise_p = m_deb_p; end
      m_rise_q = 0;
      if (hq[D+1:2] == {D{~m_deb_q}}) begin m_deb_q = ~m_deb_q; m_rise_q = m_deb_q; end
    end
  end

  function automatic logic [W+2:0] dut_vec();
    return {PUSH, POP, REJECT, DATA_OUT};
  endfunction

  function automatic logic [W+2:0] model_vec();
    return {m_push, m_pop, m_rej, m_data};
  endfunction

  task automatic idle_release();
    @(negedge CLK);
    BTN_PUSH = 1'b0;
    BTN_POP  = 1'b0;
    repeat (12) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    vectors++;
    if (dut_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want all zero", dut_vec());
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_clean_push();
    @(negedge CLK);
    DATA_RAW = 4'h1; FULL = 1'b0; EMPTY = 1'b0; BTN_PUSH = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge CLK); #1;
      vectors++;
      if ({PUSH, REJECT} !== {1'(e == 7), 1'b0}) begin
        miscompares++;
        $display("FAIL clean_push edge %0d: PUSH/REJECT=%b%b want %b0", e, PUSH, REJECT, e == 7);
      end
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL clean_push_model edge %0d: got %b want %b", e, dut_vec(), model_vec());
      end
    end
    vectors++;
    if (DATA_OUT !== 4'h1) begin
      miscompares++;
      $display("FAIL clean_push_data: got %h want 1", DATA_OUT);
    end
  endtask

  task automatic test_glitch();
    idle_release();
    BTN_PUSH = 1'b1;
    repeat (3) @(negedge CLK);
    BTN_PUSH = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK); #1;
      vectors++;
      if ({PUSH, REJECT} !== 2'b00 || dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL glitch cycle %0d: got %b want %b", c, dut_vec(), model_vec());
      end
    end
    // A fresh press must still take the full latency, so the glitch left no count behind.
    @(negedge CLK);
    BTN_PUSH = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge CLK); #1;
      vectors++;
      if (PUSH !== 1'(e == 7)) begin
        miscompares++;
        $display("FAIL glitch_repress edge %0d: PUSH=%b want %b", e, PUSH, e == 7);
      end
    end
  endtask

  task automatic test_full_reject();
    idle_release();
    DATA_RAW = 4'hA; FULL = 1'b1;
    BTN_PUSH = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge CLK); #1;
      vectors++;
      if ({PUSH, REJECT, DATA_OUT} !== {1'b0, 1'(e == 7), 4'h1}) begin
        miscompares++;
        $display("FAIL full_reject edge %0d: PUSH/REJECT/DATA=%b/%b/%h want 0/%b/1", e, PUSH, REJECT, DATA_OUT, e == 7);
      end
    end
    FULL = 1'b0;
  endtask

  task automatic test_pop_empty();
    idle_release();
    EMPTY = 1'b1;
    BTN_POP = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge CLK); #1;
      vectors++;
      if ({POP, REJECT} !== {1'b0, 1'(e == 7)}) begin
        miscompares++;
        $display("FAIL pop_empty edge %0d: POP/REJECT=%b%b want 0%b", e, POP, REJECT, e == 7);
      end
    end
    EMPTY = 1'b0;
    idle_release();
    BTN_POP = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge CLK); #1;
      vectors++;
      if ({POP, REJECT, PUSH} !== {1'(e == 7), 2'b00}) begin
        miscompares++;
        $display("FAIL pop_ok edge %0d: POP/REJECT/PUSH=%b%b%b want %b00", e, POP, REJECT, PUSH, e == 7);
      end
    end
  endtask

  task automatic test_simultaneous();
    idle_release();
    FULL = 1'b0; EMPTY = 1'b1; DATA_RAW = 4'h6;
    BTN_PUSH = 1'b1; BTN_POP = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      @(posedge CLK); #1;
      vectors++;
      if ({PUSH, POP, REJECT} !== {1'(e == 7), 1'(e == 8), 1'b0}) begin
        miscompares++;
        $display("FAIL simultaneous edge %0d: PUSH/POP/REJECT=%b%b%b want %b%b0", e, PUSH, POP, REJECT, e == 7, e == 8);
      end
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL simultaneous_model edge %0d: got %b want %b", e, dut_vec(), model_vec());
      end
      if (e == 7) EMPTY = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    idle_release();
    DATA_RAW = 4'h5;
    BTN_PUSH = 1'b1;
    repeat (7) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    vectors++;
    if (dut_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_during_push: got %b want all zero", dut_vec());
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    vectors++;
    if (dut_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_count: got %b want all zero", dut_vec());
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge CLK); #1;
      vectors++;
      if ({PUSH, REJECT} !== {1'(e == 7), 1'b0} || DATA_OUT !== (e >= 7 ? 4'h5 : 4'h0)) begin
        miscompares++;
        $display("FAIL reset_held_push edge %0d: PUSH/REJECT/DATA=%b%b/%h want %b0", e, PUSH, REJECT, DATA_OUT, e == 7);
      end
    end
  endtask

  task automatic test_random();
    int hold_p, hold_q;
    hold_p = 0;
    hold_q = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK);
      if (hold_p == 0) begin BTN_PUSH = ~BTN_PUSH; hold_p = $urandom_range(1, 9); end
      else hold_p--;
      if (hold_q == 0) begin BTN_POP = ~BTN_POP; hold_q = $urandom_range(1, 9); end
      else hold_q--;
      FULL     = ($urandom_range(0, 3) == 0);
      EMPTY    = ($urandom_range(0, 3) == 0);
      DATA_RAW = W'($urandom);
      @(posedge CLK); #1;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %b want %b", c, dut_vec(), model_vec());
      end
      vectors++;
      if (PUSH && POP) begin
        miscompares++;
        $display("FAIL random_exclusive cycle %0d: PUSH=%b POP=%b want not both", c, PUSH, POP);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_push();
    test_glitch();
    test_full_reject();
    test_pop_empty();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
